// File: rtl/mux_arb_nway.sv
// N-way round-robin arbiter/mux with valid/ready handshakes and a registered output stage.
// Optional MUX_ARB_FORCE_EN adds force_en/force_sel to restrict eligibility to one channel.
module mux_arb_nway #(
  parameter int unsigned  N     = 8,
  parameter int unsigned  WIDTH = 16,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [0:N*WIDTH-1] in,
  input  logic [0:N-1]       in_valid,
  output logic [0:N-1]       in_ready,
  output logic [0:WIDTH-1]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:SELW-1]    out_sel
`ifdef MUX_ARB_FORCE_EN
  ,
  input  logic               force_en,
  input  logic [0:SELW-1]    force_sel
`endif
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [SELW-1:0]  grant_idx;
  logic             grant_found;
  logic [SELW:0]    scan_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load;

  assign load = !valid_q || out_ready;

  // Scan ptr, ptr+1, ... with an explicit wrap at N so non-power-of-two N never aliases.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
`ifdef MUX_ARB_FORCE_EN
    if (force_en) begin
      if ({1'b0, force_sel} < (SELW+1)'(N)) begin
        grant_idx   = force_sel;
        grant_found = in_valid[force_sel];
      end
    end else
`endif
    begin
      for (int unsigned k = 0; k < N; k++) begin
        scan_idx = {1'b0, ptr_q} + (SELW+1)'(k);
        if (scan_idx >= (SELW+1)'(N)) begin
          scan_idx = scan_idx - (SELW+1)'(N);
        end
        if (!grant_found && in_valid[scan_idx[SELW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = scan_idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (load && grant_found && rst_n) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = grant_found;
      if (grant_found) begin
        out_d = grant_data;
        sel_d = grant_idx;
`ifdef MUX_ARB_FORCE_EN
        if (!force_en)
`endif
        ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_nway.sv
// Self-checking bench for mux_arb_nway: an N=8 instance (table + scoreboard) and an N=5 instance
// for wrap behaviour. Force-mode checks are compiled in when MUX_ARB_FORCE_EN is defined.
module tb_mux_arb_nway;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:8*W-1] in8;
  logic [0:7]     v8, r8;
  logic [0:W-1]   o8;
  logic           ov8, ordy8;
  logic [0:2]     os8;

  logic [0:5*W-1] in5;
  logic [0:4]     v5, r5;
  logic [0:W-1]   o5;
  logic           ov5, ordy5;
  logic [0:2]     os5;

`ifdef MUX_ARB_FORCE_EN
  logic       fe8, fe5;
  logic [0:2] fs8, fs5;
`endif

  mux_arb_nway #(.N(8), .WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .in_valid(v8), .in_ready(r8), .out(o8),
    .out_valid(ov8), .out_ready(ordy8), .out_sel(os8)
`ifdef MUX_ARB_FORCE_EN
    , .force_en(fe8), .force_sel(fs8)
`endif
  );

  mux_arb_nway #(.N(5), .WIDTH(W)) dut5 (
    .clk(clk), .rst_n(rst_n), .in(in5), .in_valid(v5), .in_ready(r5), .out(o5),
    .out_valid(ov5), .out_ready(ordy5), .out_sel(os5)
`ifdef MUX_ARB_FORCE_EN
    , .force_en(fe5), .force_sel(fs5)
`endif
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  sel;
  } exp_t;
  exp_t sbq[$];

  // Bit i of valid/exp_ready is channel i.
  typedef struct {
    logic [7:0]  valid;
    logic [15:0] base;
    logic [7:0]  exp_ready;
    int          exp_sel;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flip8(input logic [0:7] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[i];
    return r;
  endfunction

  function automatic logic [4:0] flip5(input logic [0:4] a);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = a[i];
    return r;
  endfunction

  // Channel i carries base+i.
  task automatic drive8(input logic [7:0] valid, input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      v8[i] = valid[i];
      in8[i*W +: W] = base + 16'(i);
    end
  endtask

  task automatic drive5(input logic [4:0] valid, input logic [15:0] base);
    for (int i = 0; i < 5; i++) begin
      v5[i] = valid[i];
      in5[i*W +: W] = base + 16'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [15:0] data, input int sel);
    exp_t e;
    e.data = data;
    e.sel  = 3'(sel);
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input string name);
    exp_t e;
    check({name, "_valid"}, 32'(ov8), 32'd1);
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: output seen with no expected entry queued", name);
    end else begin
      e = sbq.pop_front();
      check({name, "_data"}, 32'(o8), 32'(e.data));
      check({name, "_sel"}, 32'(os8), 32'(e.sel));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'b0000_0100, 16'hBEED, 8'b0000_0100, 2};
    vecs[1] = '{8'b0010_0010, 16'h1000, 8'b0010_0000, 5};
    vecs[2] = '{8'b0010_0010, 16'h2000, 8'b0000_0010, 1};
    vecs[3] = '{8'b0000_0001, 16'h3000, 8'b0000_0001, 0};
    vecs[4] = '{8'b1000_0010, 16'h4000, 8'b0000_0010, 1};
    vecs[5] = '{8'b1000_0000, 16'h5000, 8'b1000_0000, 7};
    vecs[6] = '{8'b1000_0001, 16'h6000, 8'b0000_0001, 0};
    vecs[7] = '{8'b0000_0000, 16'h7000, 8'b0000_0000, -1};
    vecs[8] = '{8'b1111_1111, 16'h8000, 8'b0000_0010, 1};

    in8 = '0; v8 = '1; ordy8 = 1'b1;
    in5 = '0; v5 = '1; ordy5 = 1'b1;
`ifdef MUX_ARB_FORCE_EN
    fe8 = 1'b0; fs8 = '0; fe5 = 1'b0; fs5 = '0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready8", 32'(flip8(r8)), 32'h0);
    check("rst_ready5", 32'(flip5(r5)), 32'h0);
    check("rst_out", 32'(o8), 32'h0);
    check("rst_valid", 32'(ov8), 32'h0);
    check("rst_sel", 32'(os8), 32'h0);
    v8 = '0;
    v5 = '0;
    rst_n = 1'b1;

    // Table of single-cycle vectors with out_ready held high.
    for (int t = 0; t < 9; t++) begin
      drive8(vecs[t].valid, vecs[t].base);
      #1;
      check($sformatf("vec%0d_ready", t), 32'(flip8(r8)), 32'(vecs[t].exp_ready));
      if (vecs[t].exp_sel >= 0) sb_push(vecs[t].base + 16'(vecs[t].exp_sel), vecs[t].exp_sel);
      tick();
      if (vecs[t].exp_sel >= 0) sb_pop($sformatf("vec%0d", t));
      else check($sformatf("vec%0d_valid", t), 32'(ov8), 32'h0);
    end

    // Round-robin from reset with all channels valid: 0..7,0 and no bubbles.
    v8 = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive8(8'hFF, 16'h0100);
    for (int c = 0; c < 9; c++) begin
      sb_push(16'h0100 + 16'(c % 8), c % 8);
      tick();
      sb_pop($sformatf("rr%0d", c));
    end

    // Asynchronous reset while a word is held; it must not reappear afterwards.
    drive8(8'b0000_0001, 16'h1234);
    tick();
    ordy8 = 1'b0;
    check("hold_out", 32'(o8), 32'h1234);
    check("hold_valid", 32'(ov8), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(o8), 32'h0);
    check("arst_valid", 32'(ov8), 32'h0);
    check("arst_sel", 32'(os8), 32'h0);
    check("arst_ready", 32'(flip8(r8)), 32'h0);
    ordy8 = 1'b1;
    v8 = '0;
    rst_n = 1'b1;
    tick();
    check("no_replay_valid", 32'(ov8), 32'h0);

    // Backpressure: hold AAAA for 5 cycles, then release and grant channel 5 (ptr=4).
    drive8(8'b0000_1000, 16'hAAA7);
    tick();
    ordy8 = 1'b0;
    check("bp_load_out", 32'(o8), 32'hAAAA);
    check("bp_load_sel", 32'(os8), 32'd3);
    drive8(8'b0010_0010, 16'h5000);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_ready", c), 32'(flip8(r8)), 32'h0);
      tick();
      check($sformatf("bp%0d_out", c), 32'(o8), 32'hAAAA);
      check($sformatf("bp%0d_valid", c), 32'(ov8), 32'h1);
    end
    ordy8 = 1'b1;
    #1;
    check("bp_rel_ready", 32'(flip8(r8)), 32'(8'b0010_0000));
    tick();
    check("bp_rel_out", 32'(o8), 32'h5005);
    check("bp_rel_sel", 32'(os8), 32'd5);
    v8 = '0;
    tick();
    check("bp_drain_valid", 32'(ov8), 32'h0);

    // N=5 wrap: ptr moves to 4, then channels 4 and 0 alternate.
    drive5(5'b01000, 16'h3000);
    #1;
    check("w5_pre_ready", 32'(flip5(r5)), 32'(5'b01000));
    tick();
    check("w5_pre_sel", 32'(os5), 32'd3);
    drive5(5'b10001, 16'h4000);
    for (int c = 0; c < 3; c++) begin
      int s;
      s = (c % 2 == 0) ? 4 : 0;
      #1;
      check($sformatf("w5_%0d_ready", c), 32'(flip5(r5)), 32'(5'b00001 << s));
      tick();
      check($sformatf("w5_%0d_sel", c), 32'(os5), 32'(s));
      check($sformatf("w5_%0d_out", c), 32'(o5), 32'(16'h4000 + 16'(s)));
    end
    v5 = '0;
    tick();
    check("w5_drain_valid", 32'(ov5), 32'h0);

`ifdef MUX_ARB_FORCE_EN
    // Forced channel 3 with all valid; ptr (6) must survive the forced grants.
    fe8 = 1'b1;
    fs8 = 3'd3;
    drive8(8'hFF, 16'h9000);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("f8_%0d_ready", c), 32'(flip8(r8)), 32'(8'b0000_1000));
      tick();
      check($sformatf("f8_%0d_sel", c), 32'(os8), 32'd3);
      check($sformatf("f8_%0d_out", c), 32'(o8), 32'h9003);
    end
    fe8 = 1'b0;
    #1;
    check("f8_unforce_ready", 32'(flip8(r8)), 32'(8'b0100_0000));
    tick();
    check("f8_unforce_sel", 32'(os8), 32'd6);
    v8 = '0;
    tick();

    // Out-of-range force on N=5: no grant, held word drains.
    ordy5 = 1'b0;
    drive5(5'b00010, 16'h6000);
    tick();
    check("f5_load_sel", 32'(os5), 32'd1);
    fe5 = 1'b1;
    fs5 = 3'd7;
    drive5(5'b11111, 16'h7000);
    #1;
    check("f5_hold_ready", 32'(flip5(r5)), 32'h0);
    tick();
    check("f5_hold_valid", 32'(ov5), 32'h1);
    ordy5 = 1'b1;
    #1;
    check("f5_oor_ready", 32'(flip5(r5)), 32'h0);
    tick();
    check("f5_drain_valid", 32'(ov5), 32'h0);
    fe5 = 1'b0;
    v5 = '0;
`endif

    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
